rotate100_feeder: RTL and testbench
===================================

// Module: rotate100_feeder
// PURPOSE
//  Upstream command stage for the 100-bit left/right rotator.
//  - Collects a 100-bit word from a narrow chunk stream using a valid/ready handshake.
//  - Captures a direction and a rotate amount with the word.
//  - Drives the rotator's load and ena[1:0] so the word is loaded, then rotated amt places.
//  - Pulses done when the rotator's q holds the final result.
// PARAMETERS
//  WIDTH    100  rotator width; must equal the downstream rotator width
//  CHUNK_W  10   bits per input beat; WIDTH % CHUNK_W == 0; NBEATS = WIDTH/CHUNK_W (localparam)
//  AMT_W    7    width of the rotate amount; 2**AMT_W <= 2*WIDTH
// PORTS
//  clk        in   1        clock, all state on posedge
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        chunk/command beat valid
//  in_ready   out  1        feeder accepts a beat this cycle
//  in_chunk   in   CHUNK_W  data chunk, MSB chunk first
//  in_dir     in   1        0 = rotate right, 1 = rotate left; sampled on the last beat only
//  in_amt     in   AMT_W    rotate amount; sampled on the last beat only
//  load       out  1        to rotator load
//  ena        out  2        to rotator ena: 01 = right, 10 = left, 00 = hold
//  data       out  WIDTH    to rotator data; the assembled word
//  busy       out  1        high whenever state != COLLECT
//  done       out  1        one-cycle pulse: rotator q holds the final result
// BEHAVIOUR
//  Reset values
//  - state=COLLECT, beat count=0, data=0, load=0, ena=00, done=0, busy=0.
//  - The rotator has no reset. Its q is undefined until the first load.
//  Outputs and handshake
//  - load, ena and done are registered outputs.
//  - load and ena!=00 are never asserted in the same cycle.
//  - A beat is accepted when in_valid & in_ready. in_ready=1 only in COLLECT.
//  - in_valid while busy is ignored and no data is lost on the feeder side.
//  Word assembly
//  - On each accepted beat: data <= {data[WIDTH-CHUNK_W-1:0], in_chunk}; count increments.
//  - The first beat ends up in data[WIDTH-1 -: CHUNK_W].
//  - Gaps in in_valid between beats are allowed.
//  - data is held stable from the last beat until the next accepted beat.
//  Last beat (beat NBEATS, count==NBEATS-1)
//  - Capture dir=in_dir.
//  - Capture rem = (in_amt >= WIDTH) ? in_amt-WIDTH : in_amt, i.e. amt mod WIDTH.
//  - Clear count. Go to LOAD.
//  States (last beat accepted in cycle T)
//  - COLLECT: as above.
//  - LOAD: cycle T+1. load=1, ena=00. If rem==0 go to DONE, else go to ROT.
//  - ROT: cycles T+2 .. T+1+rem.
//    - ena=01 if dir=0, ena=10 if dir=1.
//    - rem decrements each cycle; leave to DONE after the cycle where rem==1.
//  - DONE: cycle T+2+rem (T+2 when rem==0). done=1, ena=00. Return to COLLECT.
//  Latency
//  - in_ready returns high the cycle after DONE.
//  - The next word's first beat may be accepted in that cycle.
//  - Throughput is NBEATS+2+rem cycles per word at minimum.
//  Boundaries
//  - amt=0 and amt=WIDTH: no ena cycles.
//  - amt=WIDTH-1 and amt=2**AMT_W-1: full rotate counts, no wrap error.
//  - dir is meaningless when rem==0.
//  Reset mid-operation (in any state)
//  - Next cycle load=0, ena=00, done=0 and state=COLLECT.
//  - The partial word and count are discarded.
//  - The rotator keeps whatever q it had.
// TESTING (CHUNK_W=10, WIDTH=100; bench instantiates the feeder driving a rotate100)
//  1 Reset, then idle -> in_ready=1, busy=0, load=0, ena=00, done=0, data=0.
//  2 Beats 0,1,..,9, dir=1, amt=0 -> data={10'd0,10'd1,..,10'd9}; load at T+1, no ena; done at T+2; q==data.
//  3 Beats all 0 except the last =1, dir=0, amt=1 -> one ena=01 cycle; done at T+3; q=1<<99.
//  4 Same word, dir=1, amt=127 -> exactly 27 ena=10 cycles; done at T+29; q=1<<27.
//  5 in_valid gaps of 0-3 cycles between beats, plus in_valid held high during busy -> correct word;
//    in_ready=0 while busy; no extra word is accepted.
//  6 reset pulsed on the 3rd ROT cycle -> next cycle ena=00, in_ready=1;
//    a fresh 10-beat word then completes normally.

Source files
------------

// File: rtl/rotate100_feeder.sv
// rtl/rotate100_feeder.sv - chunk-stream collector and load/ena sequencer for the 100-bit rotator
// Assembles WIDTH bits from CHUNK_W-bit beats, loads the rotator, then rotates amt mod WIDTH places.
module rotate100_feeder #(
  parameter int WIDTH   = 100,
  parameter int CHUNK_W = 10,
  parameter int AMT_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_chunk,
  input  logic               in_dir,
  input  logic [AMT_W-1:0]   in_amt,
  output logic               load,
  output logic [1:0]         ena,
  output logic [WIDTH-1:0]   data,
  output logic               busy,
  output logic               done
);
  localparam int NBEATS = WIDTH / CHUNK_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [31:0]      WIDTH_W   = 32'(WIDTH);

  typedef enum logic [1:0] {COLLECT, LOAD, ROT, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [WIDTH-1:0] data_n;
  logic             dir, dir_n;
  logic [AMT_W-1:0] rem, rem_n;
  logic             load_n, done_n;
  logic [1:0]       ena_n;
  logic             accept;
  logic             last_beat;
  logic [31:0]      amt_wide;
  logic [AMT_W-1:0] amt_mod;
  logic [1:0]       ena_dir;

  assign in_ready  = (state == COLLECT);
  assign busy      = (state != COLLECT);
  assign accept    = in_valid & in_ready;
  assign last_beat = (count == LAST_BEAT);
  assign ena_dir   = dir ? 2'b10 : 2'b01;

  // in_amt is below 2*WIDTH, so one conditional subtract is a full modulo
  assign amt_wide = 32'(in_amt);
  assign amt_mod  = (amt_wide >= WIDTH_W) ? AMT_W'(amt_wide - WIDTH_W) : in_amt;

  always_comb begin
    state_n = state;
    count_n = count;
    data_n  = data;
    dir_n   = dir;
    rem_n   = rem;
    load_n  = 1'b0;
    ena_n   = 2'b00;
    done_n  = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          data_n = {data[WIDTH-CHUNK_W-1:0], in_chunk};
          if (last_beat) begin
            count_n = '0;
            dir_n   = in_dir;
            rem_n   = amt_mod;
            load_n  = 1'b1;
            state_n = LOAD;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      LOAD: begin
        if (rem == '0) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          ena_n   = ena_dir;
          state_n = ROT;
        end
      end
      ROT: begin
        // ena for this cycle was registered on entry; decide whether another shift follows
        rem_n = rem - 1'b1;
        if (rem == AMT_W'(1)) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          ena_n = ena_dir;
        end
      end
      DONE: begin
        state_n = COLLECT;
      end
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      count <= '0;
      data  <= '0;
      dir   <= 1'b0;
      rem   <= '0;
      load  <= 1'b0;
      ena   <= 2'b00;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      data  <= data_n;
      dir   <= dir_n;
      rem   <= rem_n;
      load  <= load_n;
      ena   <= ena_n;
      done  <= done_n;
    end
  end

  a_load_ena_exclusive: assert property (@(posedge clk) disable iff (reset) !(load && (ena != 2'b00)));

endmodule

// File: tb/tb_rotate100_feeder.sv
// tb/tb_rotate100_feeder.sv - scoreboard bench for rotate100_feeder driving a rotate100 model
// Driver pushes expected results; a negedge monitor pops and compares on each done pulse.
module tb_rotate100_feeder;
  localparam int WIDTH   = 100;
  localparam int CHUNK_W = 10;
  localparam int AMT_W   = 7;
  localparam int NBEATS  = 10;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [CHUNK_W-1:0] in_chunk = '0;
  logic               in_dir = 1'b0;
  logic [AMT_W-1:0]   in_amt = '0;
  logic               load;
  logic [1:0]         ena;
  logic [WIDTH-1:0]   data;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   q = '0;

  int n_checks = 0;
  int n_fails = 0;
  int cyc = 0;
  int t_last = 0;
  int accepted = 0;
  int beats_sent = 0;
  int words_done = 0;
  int load_cyc = -1;
  int ena_cnt = 0;
  logic [1:0] ena_code = 2'b00;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] qv;
    int               offset;
    int               ena_n;
    logic [1:0]       code;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  rotate100_feeder #(.WIDTH(WIDTH), .CHUNK_W(CHUNK_W), .AMT_W(AMT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_chunk(in_chunk), .in_dir(in_dir), .in_amt(in_amt),
    .load(load), .ena(ena), .data(data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // downstream rotator: ena 01 rotates right, 10 rotates left, no reset
  always @(posedge clk) begin
    if (load) q <= data;
    else if (ena == 2'b01) q <= {q[0], q[WIDTH-1:1]};
    else if (ena == 2'b10) q <= {q[WIDTH-2:0], q[WIDTH-1]};
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("ready_vs_busy", in_ready, !busy);
      if (load && ena != 2'b00) check("load_with_ena", 1, 0);
      if (in_valid && in_ready) accepted++;
      if (load) begin
        load_cyc = cyc;
        ena_cnt  = 0;
        ena_code = 2'b00;
      end
      if (ena != 2'b00) begin
        ena_cnt++;
        ena_code = ena;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("word", data, e.word);
          check("q", q, e.qv);
          check("done_latency", cyc - t_last, e.offset);
          check("load_latency", load_cyc - t_last, 0);
          check("ena_cycles", ena_cnt, e.ena_n);
          check("ena_code", ena_code, e.code);
          words_done++;
        end
      end
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] qv,
                          input int off, input int n, input logic [1:0] code);
    exp_t x;
    x.word = w; x.qv = qv; x.offset = off; x.ena_n = n; x.code = code;
    sb.push_back(x);
  endtask

  // Called and returns at #1 after a posedge; gaps of (beat % (gap_max+1)) idle cycles per beat
  task automatic send_word(input logic [CHUNK_W-1:0] ch [NBEATS], input logic d,
                           input logic [AMT_W-1:0] a, input int gap_max, input bit hold_busy);
    for (int b = 0; b < NBEATS; b++) begin
      int g;
      int w;
      g = (gap_max > 0) ? (b % (gap_max + 1)) : 0;
      in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_chunk = ch[b];
      in_dir   = (b == NBEATS - 1) ? d : ~d;
      in_amt   = (b == NBEATS - 1) ? a : 7'h55;
      w = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        w++;
        if (w > 300) begin check("accept_timeout", 1, 0); break; end
      end
      @(posedge clk); #1;
      beats_sent++;
    end
    t_last = cyc;
    if (hold_busy) begin
      in_chunk = 10'h3AA;
      for (int k = 0; k < 300; k++) begin
        @(posedge clk); #1;
        if (!busy) break;
      end
    end
    in_valid = 1'b0;
  endtask

  logic [CHUNK_W-1:0] ch [NBEATS];

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_load", load, 0);
    check("rst_ena", ena, 0);
    check("rst_done", done, 0);
    check("rst_data", data, 0);

    // beats 0..9, amt 0: load then done, no rotation
    ch = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9};
    push_exp({10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9},
             {10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9}, 1, 0, 2'b00);
    send_word(ch, 1'b1, 7'd0, 0, 1'b0);

    // word = 1, right by 1
    ch = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd1};
    push_exp(100'd1, {1'b1, 99'd0}, 2, 1, 2'b01);
    send_word(ch, 1'b0, 7'd1, 0, 1'b0);

    // word = 1, left by 127 -> 27
    push_exp(100'd1, 100'd1 << 27, 28, 27, 2'b10);
    send_word(ch, 1'b1, 7'd127, 0, 1'b0);

    // word = 1, right by 99 == left by 1
    push_exp(100'd1, 100'd2, 100, 99, 2'b01);
    send_word(ch, 1'b0, 7'd99, 0, 1'b0);

    // gaps 0..3 between beats, in_valid held during busy, amt = WIDTH
    ch = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'd10};
    push_exp({10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'd10},
             {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'd10}, 1, 0, 2'b00);
    send_word(ch, 1'b0, 7'd100, 3, 1'b1);

    // reset during the third ROT cycle of a 50-place rotate; no result expected
    ch = '{10'h155, 10'h2AA, 10'h155, 10'h2AA, 10'h155, 10'h2AA, 10'h155, 10'h2AA, 10'h155, 10'h2AA};
    send_word(ch, 1'b1, 7'd50, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("rot3_ena", ena, 2'b10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ena", ena, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_load", load, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);

    // fresh word after abort: 1<<99, left by 1
    ch = '{10'h200, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
    push_exp({1'b1, 99'd0}, 100'd1, 2, 1, 2'b10);
    send_word(ch, 1'b1, 7'd1, 0, 1'b0);

    for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("words_done", words_done, 6);
    check("beats_accepted", accepted, beats_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
